// File: rtl/if_stage.sv
// if_stage: MIPS32 instruction-fetch front end (PC, ROM interface, IF/ID latch).
// Optional IF_FETCH_CNT_EN adds fetch_cnt_o counting instructions loaded into IF/ID.
module if_stage #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              if_misalign_o
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o
`endif
);
  typedef enum logic {OFF, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_next;
  logic id_clr, id_load;
  logic unused_stall;
  assign unused_stall = ^stall[5:3];
  assign rom_addr_o = pc;
  assign rom_ce_o = (state == RUN);
  always_comb begin
    state_nxt = RUN;
    pc_next = (state == OFF) ? RESET_PC :
              flush          ? new_pc :
              stall[0]       ? pc :
              branch_flag_i  ? branch_target_address_i :
                               pc + ADDR_W'(4);
    id_clr  = (state == OFF) || flush || (stall[1] && !stall[2]);
    id_load = !stall[1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      pc <= RESET_PC;
      if_misalign_o <= 1'b0;
    end else begin
      state <= state_nxt;
      pc <= pc_next;
      if (state == RUN) if_misalign_o <= |pc_next[1:0];
    end
  end
  // a branch never kills the fetch in flight, so the delay slot reaches IF/ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_o <= '0;
      id_inst_o <= '0;
    end else if (id_clr) begin
      id_pc_o <= '0;
      id_inst_o <= '0;
    end else if (id_load) begin
      id_pc_o <= pc;
      id_inst_o <= rom_ce_o ? rom_inst_i : '0;
    end
  end
`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt_o <= '0;
    else if (state == RUN && !flush && !stall[1]) fetch_cnt_o <= fetch_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus with a behavioural fetch model compared every cycle.
module tb_if_stage;
  logic clk = 0, rst = 0;
  logic [5:0] stall = '0;
  logic flush = 0, branch = 0;
  logic [31:0] new_pc = '0, bt = '0;
  logic [31:0] rom_inst, rom_addr, id_pc, id_inst;
  logic rom_ce, mis;
  logic [31:0] rom [0:255];
  int n_chk = 0, n_fail = 0;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] cnt;
`endif
  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch), .branch_target_address_i(bt), .rom_inst_i(rom_inst),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .id_pc_o(id_pc), .id_inst_o(id_inst),
    .if_misalign_o(mis)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt_o(cnt)
`endif
  );
  always #5 clk = ~clk;
  assign rom_inst = rom[rom_addr[9:2]];
  logic unused_bits;
  assign unused_bits = ^{rom_addr[31:10], rom_addr[1:0]};

  // model: fetch state described directly from the behavioural rules
  logic m_run;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;
  logic m_mis;
  function automatic logic [31:0] target(input logic [31:0] cur);
    if (flush) return new_pc;
    if (stall[0]) return cur;
    if (branch) return bt;
    return cur + 32'd4;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_pc <= 0; m_id_pc <= 0; m_id_inst <= 0; m_mis <= 0; m_cnt <= 0;
    end else if (!m_run) begin
      m_run <= 1; m_id_pc <= 0; m_id_inst <= 0;
    end else begin
      m_pc <= target(m_pc);
      m_mis <= target(m_pc) % 4 != 0;
      if (flush || (stall[1] && !stall[2])) begin
        m_id_pc <= 0; m_id_inst <= 0;
      end else if (!stall[1]) begin
        m_id_pc <= m_pc; m_id_inst <= rom[m_pc[9:2]];
      end
      if (!flush && !stall[1]) m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rom_addr", rom_addr, m_pc);
    chk("rom_ce", {31'd0, rom_ce}, {31'd0, m_run});
    chk("id_pc", id_pc, m_id_pc);
    chk("id_inst", id_inst, m_id_inst);
    chk("misalign", {31'd0, mis}, {31'd0, m_mis});
`ifdef IF_FETCH_CNT_EN
    chk("fetch_cnt", cnt, m_cnt);
`endif
  end

  task automatic cyc(input logic [5:0] s, input logic f, input logic [31:0] np,
                     input logic b, input logic [31:0] t);
    stall = s; flush = f; new_pc = np; branch = b; bt = t;
    @(negedge clk);
  endtask

  initial begin
    rom[0] = 32'h34014044;
    rom[1] = 32'h34220000;
    for (int i = 2; i < 256; i++) rom[i] = 32'hA500_0000 | i;
    #1 rst = 1;
    @(negedge clk);
    chk("lit_reset_ce", {31'd0, rom_ce}, 32'd0);
    chk("lit_reset_inst", id_inst, 32'd0);
    rst = 0;
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_ce_on", {31'd0, rom_ce}, 32'd1);
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_first_inst", id_inst, 32'h34014044);
    chk("lit_first_pc", id_pc, 32'd0);
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_second_inst", id_inst, 32'h34220000);
    chk("lit_second_pc", id_pc, 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(6'b000011, 0, 0, 0, 0);
      chk("lit_stall_pc", rom_addr, 32'd8);
      chk("lit_stall_bubble", id_inst, 32'd0);
    end
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_release_idpc", id_pc, 32'd8);
    chk("lit_release_pc", rom_addr, 32'd12);
    for (int i = 0; i < 2; i++) begin
      cyc(6'b000111, 0, 0, 0, 0);
      chk("lit_hold_pc", rom_addr, 32'd12);
      chk("lit_hold_idpc", id_pc, 32'd8);
      chk("lit_hold_inst", id_inst, rom[2]);
    end
    cyc(6'b0, 0, 0, 0, 0);
    cyc(6'b0, 0, 0, 1, 32'h40);
    chk("lit_branch_pc", rom_addr, 32'h40);
    chk("lit_delay_slot", id_pc, 32'h10);
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_target_idpc", id_pc, 32'h40);
    cyc(6'b000001, 0, 0, 1, 32'h80);
    chk("lit_branch_dropped", rom_addr, 32'h44);
    cyc(6'b000001, 1, 32'h180, 1, 32'h80);
    chk("lit_flush_pc", rom_addr, 32'h180);
    chk("lit_flush_idpc", id_pc, 32'd0);
    chk("lit_flush_inst", id_inst, 32'd0);
    cyc(6'b0, 0, 0, 0, 0);
    cyc(6'b0, 1, 32'h182, 0, 0);
    chk("lit_misalign", {31'd0, mis}, 32'd1);
    cyc(6'b0, 0, 0, 0, 0);
    cyc(6'b0, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_wrap", rom_addr, 32'd0);
    chk("lit_wrap_idpc", id_pc, 32'hFFFF_FFFC);
    cyc(6'b0, 1, 32'h20, 0, 0);
    chk("lit_aligned", {31'd0, mis}, 32'd0);
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_pre_rst_pc", rom_addr, 32'h24);
    #2 rst = 1;
    #1;
    chk("lit_async_addr", rom_addr, 32'd0);
    chk("lit_async_ce", {31'd0, rom_ce}, 32'd0);
    chk("lit_async_idpc", id_pc, 32'd0);
    chk("lit_async_inst", id_inst, 32'd0);
`ifdef IF_FETCH_CNT_EN
    chk("lit_async_cnt", cnt, 32'd0);
`endif
    #1 rst = 0;
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_resume_ce", {31'd0, rom_ce}, 32'd1);
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_resume_inst", id_inst, 32'h34014044);
`ifdef IF_FETCH_CNT_EN
    chk("lit_cnt1", cnt, 32'd1);
`endif
    cyc(6'b0, 0, 0, 0, 0);
    chk("lit_resume_pc", id_pc, 32'd4);
`ifdef IF_FETCH_CNT_EN
    chk("lit_cnt2", cnt, 32'd2);
`endif
    cyc(6'b000010, 0, 0, 0, 0);
    cyc(6'b0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch front end of the MIPS32 pipeline.
- Holds the program counter and drives address plus chip-enable to the combinational instruction ROM.
- Registers the ROM's returned instruction with its PC into the IF/ID pipeline latch for decode.
- Applies the pipeline-control stall vector, taken branches (delay slot preserved) and flush-to-new-PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC / instruction address width.
- INST_W, 32, instruction word width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  6  pipeline stall vector; bit0 = PC stage, bit1 = IF stage, bit2 = ID stage; bits 5:3 ignored here.
- flush  in  1  pipeline flush (exception/eret).
- new_pc  in  ADDR_W  redirect target used with flush.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_address_i  in  ADDR_W  branch/jump target.
- rom_inst_i  in  INST_W  instruction returned by the instruction ROM, same cycle as rom_addr_o.
- rom_addr_o  out  ADDR_W  fetch address (= pc); ROM word-indexes on bits above [1:0].
- rom_ce_o  out  1  ROM chip enable.
- id_pc_o  out  ADDR_W  PC of the instruction held in IF/ID.
- id_inst_o  out  INST_W  instruction held in IF/ID; 0 = NOP/bubble.
- if_misalign_o  out  1  registered flag: current pc[1:0] != 0.

Behaviour:
- Reset (async, rst=1), all outputs forced immediately: pc = RESET_PC, rom_ce_o = 0, id_pc_o = 0, id_inst_o = 0, if_misalign_o = 0.
- Two-state FSM:
  - OFF: entered on reset; rom_ce_o = 0; pc held at RESET_PC; IF/ID loads zero each edge.
  - RUN: entered on the first rising edge with rst=0; rom_ce_o = 1; never leaves except by reset.
  - rst asserted mid-operation returns to OFF asynchronously; no in-flight state survives.
- PC update in RUN, per edge, priority highest first:
  1. flush = 1: pc <= new_pc.
  2. stall[0] = 1: pc holds.
  3. branch_flag_i = 1: pc <= branch_target_address_i.
  4. Otherwise: pc <= pc + 4. Modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- In OFF, flush and branch are ignored.
- rom_addr_o = pc, combinational; rom_ce_o is the registered FSM output.
- IF/ID latch, per edge, highest first:
  1. flush = 1: id_pc_o <= 0, id_inst_o <= 0.
  2. stall[1] = 1 and stall[2] = 0: insert bubble, both <= 0.
  3. stall[1] = 0: id_pc_o <= pc; id_inst_o <= (rom_ce_o ? rom_inst_i : 0).
  4. stall[1] = 1 and stall[2] = 1: hold.
- Delay slot: a branch does not kill the instruction currently being fetched; it enters IF/ID normally, which gives MIPS delay-slot semantics.
- Simultaneous events:
  - flush with stall[0]: flush wins; pc redirected, IF/ID cleared.
  - branch with stall[0]: pc holds and the branch is dropped. The ID stage must keep branch_flag_i asserted until the stall clears.
- Latency:
  - Instruction at address A appears on id_inst_o one edge after pc = A with stall[1] = 0.
  - Redirect via flush/branch: target fetched the following cycle, in IF/ID two edges after assertion.
- if_misalign_o <= (pc_next[1:0] != 0), registered alongside pc. Updates only when pc updates. The block does not redirect on misalignment; exception handling is external.

Optional Feature:
- Macro IF_FETCH_CNT_EN.
- Defined:
  - Adds output fetch_cnt_o (32 bits), reset to 0.
  - Increments by 1 on every edge where the FSM is RUN, stall[1] = 0 and flush = 0, i.e. a real instruction was loaded into IF/ID.
  - Wraps 32'hFFFF_FFFF -> 0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC = 0, ROM holds 34014044 at word 0 and 34220000 at word 1, no stall:
  - rom_ce_o = 1 after the first edge.
  - id_inst_o = 34014044 with id_pc_o = 0 one edge after rom_ce_o = 1.
  - id_inst_o = 34220000 with id_pc_o = 4 on the next edge.
- stall = 6'b000011 for 3 cycles starting at pc = 8:
  - pc stays 8.
  - id_inst_o = 0 for 3 edges.
  - After release, pc = 8 enters IF/ID and pc becomes 12.
- stall = 6'b000111 for 2 cycles: pc, id_pc_o and id_inst_o all hold their values.
- branch_flag_i = 1 with target 0x40 while pc = 0x10:
  - Next pc = 0x40.
  - id_pc_o = 0x10 (delay slot retained).
  - id_pc_o = 0x40 on the following edge.
- flush = 1, new_pc = 0x180, together with stall[0] = 1 and branch_flag_i = 1:
  - pc = 0x180.
  - id_pc_o = 0, id_inst_o = 0 on that edge.
- rst pulsed asynchronously mid-run at pc = 0x24: outputs go to reset values before the next clk edge, and fetch resumes from RESET_PC. With IF_FETCH_CNT_EN, fetch_cnt_o returns to 0 and counts 1, 2, … afterward.
